// File: rtl/sdram_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sdram_port_arbiter
// Function : N-port requester arbiter onto the single-port SDRAM controller.
//            Grants only on mem_slot boundaries and supports bus locking.
//            Fixed priority by default; ARB_ROUND_ROBIN_EN selects round robin.
// Revision : 1.0  initial release
// ============================================================================
module sdram_port_arbiter #(
    parameter int NUM_PORTS = 3,
    parameter int ADDR_W    = 25,
    parameter int DATA_W    = 8,
    parameter int DATA_LAT  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS-1:0]        we,
    input  logic [NUM_PORTS-1:0]        lock,
    input  logic [NUM_PORTS*ADDR_W-1:0] addr,
    input  logic [NUM_PORTS*DATA_W-1:0] wdata,
    output logic [NUM_PORTS-1:0]        ack,
    output logic [DATA_W-1:0]           rdata,
    output logic [2:0]                  grant_idx,
    output logic                        busy,
    input  logic                        mem_slot,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_din,
    output logic                        mem_we,
    output logic                        mem_oe,
    input  logic [DATA_W-1:0]           mem_dout
);

    localparam int C_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int C_CNT_W = 4;

    generate
        if (NUM_PORTS < 2 || NUM_PORTS > 8) begin : g_bad_num_ports
            $error("sdram_port_arbiter: NUM_PORTS must be in 2..8");
        end
        if (DATA_LAT < 1 || DATA_LAT > 15) begin : g_bad_data_lat
            $error("sdram_port_arbiter: DATA_LAT must be in 1..15");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_q,     state_d;
    logic [C_CNT_W-1:0]   cnt_q,       cnt_d;
    logic [C_IDX_W-1:0]   grant_q,     grant_d;
    logic [C_IDX_W-1:0]   owner_q,     owner_d;
    logic                 owner_vld_q, owner_vld_d;
    logic                 busy_q,      busy_d;
    logic [NUM_PORTS-1:0] ack_q,       ack_d;
    logic [DATA_W-1:0]    rdata_q,     rdata_d;
    logic [ADDR_W-1:0]    mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0]    mem_din_q,   mem_din_d;
    logic                 mem_we_q,    mem_we_d;
    logic                 mem_oe_q,    mem_oe_d;

    logic [ADDR_W-1:0]    w_addr_arr  [NUM_PORTS];
    logic [DATA_W-1:0]    w_wdata_arr [NUM_PORTS];
    logic [C_IDX_W-1:0]   w_win;
    logic                 w_lock_hit;

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign w_addr_arr[g]  = addr[g*ADDR_W +: ADDR_W];
        assign w_wdata_arr[g] = wdata[g*DATA_W +: DATA_W];
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [C_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [C_IDX_W-1:0] w_cand;
    logic               w_found;
`endif

    // A recorded lock owner that is still requesting overrides the base policy.
    always_comb begin
        w_win      = '0;
        w_lock_hit = owner_vld_q && req[owner_q];
`ifdef ARB_ROUND_ROBIN_EN
        w_cand  = '0;
        w_found = 1'b0;
`endif
        if (w_lock_hit) begin
            w_win = owner_q;
        end else begin
`ifdef ARB_ROUND_ROBIN_EN
            for (int k = 1; k <= NUM_PORTS; k++) begin
                w_cand = C_IDX_W'((int'(rr_ptr_q) + k) % NUM_PORTS);
                if (!w_found && req[w_cand]) begin
                    w_win   = w_cand;
                    w_found = 1'b1;
                end
            end
`else
            for (int i = NUM_PORTS - 1; i >= 0; i--) begin
                if (req[i]) w_win = C_IDX_W'(i);
            end
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        grant_d     = grant_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        busy_d      = busy_q;
        ack_d       = '0;
        rdata_d     = rdata_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_we_d    = mem_we_q;
        mem_oe_d    = mem_oe_q;
`ifdef ARB_ROUND_ROBIN_EN
        rr_ptr_d    = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (mem_slot && (|req)) begin
                    state_d     = ST_ISSUE;
                    cnt_d       = C_CNT_W'(1);
                    grant_d     = w_win;
                    owner_d     = w_win;
                    owner_vld_d = lock[w_win];
                    busy_d      = 1'b1;
                    mem_addr_d  = w_addr_arr[w_win];
                    mem_din_d   = w_wdata_arr[w_win];
                    mem_we_d    = we[w_win];
                    mem_oe_d    = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    rr_ptr_d    = w_win;
`endif
                end
            end
            ST_ISSUE, ST_WAIT: begin
                // Outputs are registered, so finishing here puts ack one cycle later.
                if (cnt_q == C_CNT_W'(DATA_LAT)) begin
                    state_d        = ST_DONE;
                    ack_d[grant_q] = 1'b1;
                    if (!mem_we_q) rdata_d = mem_dout;
                    mem_we_d       = 1'b0;
                    mem_oe_d       = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                    cnt_d   = cnt_q + C_CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            grant_q     <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            busy_q      <= 1'b0;
            ack_q       <= '0;
            rdata_q     <= '0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_oe_q    <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= C_IDX_W'(NUM_PORTS - 1);
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            grant_q     <= grant_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            busy_q      <= busy_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_we_q    <= mem_we_d;
            mem_oe_q    <= mem_oe_d;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr_q    <= rr_ptr_d;
`endif
        end
    end

    assign ack       = ack_q;
    assign rdata     = rdata_q;
    assign grant_idx = 3'(grant_q);
    assign busy      = busy_q;
    assign mem_addr  = mem_addr_q;
    assign mem_din   = mem_din_q;
    assign mem_we    = mem_we_q;
    assign mem_oe    = mem_oe_q;

endmodule
`default_nettype wire
